// File: rtl/cordic_rr_sched.sv
// Round-robin front end that shares one iterative CORDIC rotator among N requesters.
// Jobs are issued one at a time; a watchdog aborts a job if the rotator never finishes.
module cordic_rr_sched #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*DW-1:0]      req_v0,
  input  logic [N*DW-1:0]      req_v1,
  input  logic [N*DW-1:0]      req_angle,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [DW-1:0]        rsp_v0,
  output logic [DW-1:0]        rsp_v1,
  output logic                 rsp_err,
  output logic                 co_start,
  output logic [DW-1:0]        co_v0,
  output logic [DW-1:0]        co_v1,
  output logic [DW-1:0]        co_angle,
  input  logic                 co_ready,
  input  logic [DW-1:0]        co_v0_o,
  input  logic [DW-1:0]        co_v1_o,
  output logic                 busy
);
  localparam int          IW = $clog2(N);
  localparam int          WW = $clog2(TIMEOUT + 1);
  localparam int unsigned NU = N;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic          grant_any;
  logic          grant_fire;
  logic [WW-1:0] wdog;
  logic          wdog_hit;
  logic [DW-1:0] gv0;
  logic [DW-1:0] gv1;
  logic [DW-1:0] gang;

  // Scan starts one past the last winner so every requester gets a turn within N jobs.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      cand = IW'((32'(ptr) + k) % NU);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    gv0  = '0;
    gv1  = '0;
    gang = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (grant_idx == IW'(i)) begin
        gv0  = req_v0[i*DW +: DW];
        gv1  = req_v1[i*DW +: DW];
        gang = req_angle[i*DW +: DW];
      end
    end
  end

  assign grant_fire = (state == S_IDLE) && co_ready && grant_any && !reset;
  assign wdog_hit   = (wdog == WW'(TIMEOUT - 1));

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      req_ready[i] = grant_fire && (grant_idx == IW'(i));
    end
  end

  assign co_start  = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= IW'(N - 1);
      wdog     <= '0;
      rsp_id   <= '0;
      rsp_v0   <= '0;
      rsp_v1   <= '0;
      rsp_err  <= 1'b0;
      co_v0    <= '0;
      co_v1    <= '0;
      co_angle <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            ptr      <= grant_idx;
            rsp_id   <= grant_idx;
            co_v0    <= gv0;
            co_v1    <= gv1;
            co_angle <= gang;
            rsp_err  <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          wdog <= wdog + WW'(1);
          if (wdog_hit) begin
            rsp_err <= 1'b1;
            rsp_v0  <= '0;
            rsp_v1  <= '0;
            state   <= S_RESP;
          end else if (!co_ready) begin
            state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          wdog <= wdog + WW'(1);
          // A result arriving on the final watchdog cycle still wins over the abort.
          if (co_ready) begin
            rsp_v0 <= co_v0_o;
            rsp_v1 <= co_v1_o;
            state  <= S_RESP;
          end else if (wdog_hit) begin
            rsp_err <= 1'b1;
            rsp_v0  <= '0;
            rsp_v1  <= '0;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_err <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: behavioural rotator plus a cycle-timeline model of the
// scheduler, checked every cycle, with directed scenarios and literal pins.
module tb_cordic_rr_sched;
  localparam int N       = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 31;
  localparam int IW      = 2;
  localparam int ROT_LAT = 10;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_RESP  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_v0;
  logic [N*DW-1:0] req_v1;
  logic [N*DW-1:0] req_angle;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_v0;
  logic [DW-1:0]   rsp_v1;
  logic            rsp_err;
  logic            co_start;
  logic [DW-1:0]   co_v0;
  logic [DW-1:0]   co_v1;
  logic [DW-1:0]   co_angle;
  logic            co_ready;
  logic [DW-1:0]   co_v0_o;
  logic [DW-1:0]   co_v1_o;
  logic            busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_rr_sched #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_v0(req_v0), .req_v1(req_v1), .req_angle(req_angle),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_v0(rsp_v0), .rsp_v1(rsp_v1),
    .rsp_err(rsp_err), .co_start(co_start), .co_v0(co_v0), .co_v1(co_v1),
    .co_angle(co_angle), .co_ready(co_ready), .co_v0_o(co_v0_o), .co_v1_o(co_v1_o),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] sat_q87(input real r);
    int i;
    i = $rtoi(r);
    if (i > 128) i = 128;
    if (i < -128) i = -128;
    return DW'(i);
  endfunction

  function automatic logic [DW-1:0] rot_x(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic [DW-1:0] a);
    real th;
    th = $itor($signed(a)) / 16384.0;
    return sat_q87($itor($signed(x)) * $cos(th) - $itor($signed(y)) * $sin(th));
  endfunction

  function automatic logic [DW-1:0] rot_y(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic [DW-1:0] a);
    real th;
    th = $itor($signed(a)) / 16384.0;
    return sat_q87($itor($signed(x)) * $sin(th) + $itor($signed(y)) * $cos(th));
  endfunction

  // Behavioural rotator: ready low for ROT_LAT cycles after start; stuck holds it low.
  logic          rot_rdy;
  logic          stuck;
  logic          hold_low;
  int            rot_cnt;
  logic [DW-1:0] rot_xr;
  logic [DW-1:0] rot_yr;

  always @(posedge clk) begin
    if (reset) begin
      rot_rdy <= 1'b1;
      rot_cnt <= 0;
      rot_xr  <= '0;
      rot_yr  <= '0;
    end else if (rot_rdy) begin
      if (co_start) begin
        rot_rdy <= 1'b0;
        rot_cnt <= ROT_LAT - 1;
        rot_xr  <= rot_x(co_v0, co_v1, co_angle);
        rot_yr  <= rot_y(co_v0, co_v1, co_angle);
      end
    end else if (rot_cnt != 0) begin
      rot_cnt <= rot_cnt - 1;
    end else if (!stuck) begin
      rot_rdy <= 1'b1;
    end
  end

  assign co_ready = rot_rdy & ~hold_low;
  assign co_v0_o  = rot_rdy ? rot_xr : 16'hDEAD;
  assign co_v1_o  = rot_rdy ? rot_yr : 16'hBEEF;

  // Scheduler model and per-cycle compare, plus observation logs.
  int            m_st = M_IDLE;
  int            m_ptr = N - 1;
  int            m_id, m_wait, cidx;
  logic          m_low, m_err, found;
  logic [DW-1:0] m_v0, m_v1, m_a, m_e0, m_e1;
  logic [N-1:0]  e_ready;
  logic          e_start, e_rsp, e_busy;
  logic [N-1:0]  acc_mask = '0;
  int            acc_cnt[N];
  int            start_cnt = 0;
  int            cyc = 0;
  int            last_acc_cyc, last_start_cyc, last_rsp_cyc;
  logic [DW-1:0] last_v0, last_v1;
  logic          last_err;
  int            rsp_log[$];

  always @(negedge clk) begin
    cyc++;
    acc_mask = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        acc_cnt[i]++;
        last_acc_cyc = cyc;
      end
    end
    if (co_start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (rsp_valid === 1'b1) begin
      rsp_log.push_back(int'(rsp_id));
      last_v0      = rsp_v0;
      last_v1      = rsp_v1;
      last_err     = rsp_err;
      last_rsp_cyc = cyc;
    end
    if (reset) begin
      chk("req_ready_in_reset", req_ready, 0);
      m_st  = M_IDLE;
      m_ptr = N - 1;
    end else begin
      e_ready = '0;
      e_start = 1'b0;
      e_rsp   = 1'b0;
      e_busy  = (m_st != M_IDLE);
      case (m_st)
        M_IDLE: begin
          if (co_ready && req_valid != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
              cidx = (m_ptr + k) % N;
              if (!found && req_valid[cidx]) begin
                found = 1'b1;
                m_id  = cidx;
              end
            end
            e_ready[m_id] = 1'b1;
            m_ptr = m_id;
            m_v0  = req_v0[m_id*DW +: DW];
            m_v1  = req_v1[m_id*DW +: DW];
            m_a   = req_angle[m_id*DW +: DW];
            m_st  = M_ISSUE;
          end
        end
        M_ISSUE: begin
          e_start = 1'b1;
          chk("co_v0", co_v0, m_v0);
          chk("co_v1", co_v1, m_v1);
          chk("co_angle", co_angle, m_a);
          m_wait = 0;
          m_low  = 1'b0;
          m_st   = M_WAIT;
        end
        M_WAIT: begin
          m_wait++;
          if (m_low && co_ready) begin
            m_err = 1'b0;
            m_e0  = rot_x(m_v0, m_v1, m_a);
            m_e1  = rot_y(m_v0, m_v1, m_a);
            m_st  = M_RESP;
          end else begin
            if (!co_ready) m_low = 1'b1;
            if (m_wait == TIMEOUT) begin
              m_err = 1'b1;
              m_e0  = '0;
              m_e1  = '0;
              m_st  = M_RESP;
            end
          end
        end
        default: begin
          e_rsp = 1'b1;
          chk("rsp_id", rsp_id, m_id);
          chk("rsp_v0", rsp_v0, m_e0);
          chk("rsp_v1", rsp_v1, m_e1);
          m_st = M_IDLE;
        end
      endcase
      chk("req_ready", req_ready, e_ready);
      chk("co_start", co_start, e_start);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("busy", busy, e_busy);
      chk("rsp_err", rsp_err, e_rsp && m_err);
    end
  end

  int jobs_left[N];

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && jobs_left[i] > 0) jobs_left[i]--;
      req_valid[i] = (jobs_left[i] != 0);
    end
  endtask

  function automatic logic all_done();
    for (int i = 0; i < N; i++) if (jobs_left[i] != 0) return 1'b0;
    return (m_st == M_IDLE);
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!all_done() && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_done: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                         input logic [DW-1:0] a);
    req_v0[i*DW +: DW]    = v0;
    req_v1[i*DW +: DW]    = v1;
    req_angle[i*DW +: DW] = a;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_v0"}, rsp_v0, 0);
    chk({tag, "_rsp_v1"}, rsp_v1, 0);
    chk({tag, "_co_start"}, co_start, 0);
    chk({tag, "_co_v0"}, co_v0, 0);
    chk({tag, "_co_v1"}, co_v1, 0);
    chk({tag, "_co_angle"}, co_angle, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int a0, s0, n0, n;
    int ang[N];
    ang = '{16'h0000, 16'h00A2, 16'h0144, 16'h01E6};
    req_valid = '0;
    req_v0    = '0;
    req_v1    = '0;
    req_angle = '0;
    stuck     = 1'b0;
    hold_low  = 1'b0;
    for (int i = 0; i < N; i++) begin
      jobs_left[i] = 0;
      acc_cnt[i]   = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals("rst");

    // Single job from requester 0.
    set_ops(0, 16'h0080, 16'h0000, 16'h0000);
    a0 = acc_cnt[0];
    s0 = start_cnt;
    rsp_log.delete();
    jobs_left[0] = 1;
    wait_done("single");
    chk("single_rsp_count", rsp_log.size(), 1);
    if (rsp_log.size() > 0) chk("single_rsp_id", rsp_log[0], 0);
    chk("single_v0", last_v0, 16'h0080);
    chk("single_v1", last_v1, 16'h0000);
    chk("single_err", last_err, 0);
    chk("single_accepts", acc_cnt[0] - a0, 1);
    chk("single_starts", start_cnt - s0, 1);
    chk("single_start_after_accept", last_start_cyc - last_acc_cyc, 1);

    // All four requesters held valid from a fresh pointer.
    pulse_reset();
    for (int i = 0; i < N; i++) set_ops(i, 16'(16'h0040 + 8 * i), 16'(16'h0008 + 16 * i), 16'(ang[i]));
    rsp_log.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    jobs_left[0] = 2;
    jobs_left[1] = 1;
    jobs_left[2] = 1;
    jobs_left[3] = 1;
    wait_done("all4");
    chk("all4_count", rsp_log.size(), 5);
    if (rsp_log.size() == 5) begin
      chk("all4_id0", rsp_log[0], 0);
      chk("all4_id1", rsp_log[1], 1);
      chk("all4_id2", rsp_log[2], 2);
      chk("all4_id3", rsp_log[3], 3);
      chk("all4_id4", rsp_log[4], 0);
    end
    chk("all4_acc0", acc_cnt[0], 2);
    for (int i = 1; i < N; i++) chk("all4_acc", acc_cnt[i], 1);

    // Pointer at 2, requests {1,3}: 3 must win first.
    rsp_log.delete();
    jobs_left[2] = 1;
    wait_done("ptr_a");
    jobs_left[1] = 1;
    jobs_left[3] = 1;
    wait_done("ptr_b");
    chk("ptr_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) begin
      chk("ptr_first", rsp_log[1], 3);
      chk("ptr_second", rsp_log[2], 1);
    end

    // Rotator not ready while idle: no grant until it returns.
    hold_low = 1'b1;
    a0 = acc_cnt[0];
    s0 = start_cnt;
    jobs_left[0] = 1;
    repeat (8) step();
    chk("hold_no_accept", acc_cnt[0] - a0, 0);
    chk("hold_no_start", start_cnt - s0, 0);
    hold_low = 1'b0;
    wait_done("hold");
    chk("hold_accept_after", acc_cnt[0] - a0, 1);

    // Stuck rotator: watchdog abort, then recovery.
    stuck = 1'b1;
    jobs_left[1] = 1;
    wait_done("tmo");
    chk("tmo_err", last_err, 1);
    chk("tmo_v0", last_v0, 0);
    chk("tmo_v1", last_v1, 0);
    chk("tmo_latency", last_rsp_cyc - last_start_cyc, 32);
    chk("tmo_busy", busy, 0);
    stuck = 1'b0;
    n0 = rsp_log.size();
    jobs_left[3] = 1;
    wait_done("tmo_recover");
    chk("tmo_recover_count", rsp_log.size(), n0 + 1);
    chk("tmo_recover_err", last_err, 0);

    // Reset while the rotator is mid-job.
    set_ops(2, 16'h0070, 16'hFFC0, 16'h0100);
    jobs_left[2] = 1;
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      step();
      n++;
    end
    chk("rst_mid_started", start_cnt - s0, 1);
    repeat (5) step();
    n0 = rsp_log.size();
    pulse_reset();
    chk_reset_vals("rst_mid");
    repeat (15) step();
    chk("rst_mid_no_rsp", rsp_log.size(), n0);
    set_ops(0, 16'h0050, 16'h0020, 16'h00A2);
    jobs_left[0] = 1;
    wait_done("after_rst");
    chk("after_rst_count", rsp_log.size(), n0 + 1);
    if (rsp_log.size() == n0 + 1) chk("after_rst_id", rsp_log[n0], 0);
    chk("after_rst_err", last_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/cordic_rr_sched.md
Name: cordic_rr_sched

Overview:
- Round-robin scheduler that shares one iterative CORDIC rotator (start/ready handshake, Q8.7 vectors, Q2.14 angle) between N independent requesters.
- Accepts one rotation job at a time and registers its operands. Pulses the rotator start, waits out the iteration and scale phases, then returns the result tagged with the requester index.
- Sits between the rotator instance and client blocks, for example multiple phase accumulators.
- Includes a watchdog so a stuck rotator cannot hang all clients.

Parameters:
- N, 4, number of requesters (2..8).
- DW, 16, data width of v0, v1 and angle.
- TIMEOUT, 31, max cycles allowed in the WAIT_LO + WAIT_HI states before abort (must be at least 12).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester job request; held until accepted.
- req_ready  out  N  one-hot one-cycle accept pulse; the job is transferred when req_valid[i] and req_ready[i] are both high.
- req_v0  in  N*DW  packed Q8.7 x operands; slice i is [i*DW +: DW].
- req_v1  in  N*DW  packed Q8.7 y operands.
- req_angle  in  N*DW  packed Q2.14 rotation angles.
- rsp_valid  out  1  one-cycle result strobe; no backpressure.
- rsp_id  out  $clog2(N)  index of the requester that owns rsp_*.
- rsp_v0  out  DW  rotated, scaled, saturated x.
- rsp_v1  out  DW  rotated, scaled, saturated y.
- rsp_err  out  1  high with rsp_valid when the job was aborted by timeout; rsp_v0/rsp_v1 are 0 in that case.
- co_start  out  1  start pulse to the rotator.
- co_v0  out  DW  registered operand to the rotator.
- co_v1  out  DW  registered operand to the rotator.
- co_angle  out  DW  registered operand to the rotator.
- co_ready  in  1  rotator idle/done flag; 1 when idle, drops the cycle after start is sampled.
- co_v0_o  in  DW  rotator result, valid when co_ready is high after a job.
- co_v1_o  in  DW  rotator result, valid when co_ready is high after a job.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_v0=0, rsp_v1=0, co_start=0, co_v0/co_v1/co_angle=0, busy=0.
  - Internal: state=IDLE, rr pointer=N-1 (so requester 0 wins first), watchdog=0.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP.
- IDLE:
  - If any req_valid is set and co_ready=1, grant the first set bit scanning from (ptr+1) mod N upward with wrap.
  - In the same cycle: assert req_ready[g], latch the operands of g into co_v0/co_v1/co_angle, set ptr=g, latch rsp_id=g, go to ISSUE.
  - If co_ready=0, stay in IDLE and grant nothing.
- ISSUE: co_start=1 for exactly one cycle, watchdog cleared, go to WAIT_LO.
- WAIT_LO: wait for co_ready=0, then go to WAIT_HI. This guards against sampling the stale ready that is still high on the cycle after start.
- WAIT_HI: on co_ready=1, register co_v0_o/co_v1_o into rsp_v0/rsp_v1, go to RESP.
- Watchdog:
  - Increments each cycle in WAIT_LO and WAIT_HI.
  - On reaching TIMEOUT: rsp_err=1, rsp_v0=rsp_v1=0, go to RESP.
- RESP: rsp_valid=1 for one cycle, rsp_err as latched, go to IDLE. rsp_err clears on the next cycle.
- Throughput:
  - Minimum 4 scheduler cycles plus the rotator latency per job.
  - No new grant is issued in the RESP cycle; the next grant comes at the earliest in the following IDLE cycle.
- Fairness: a requester holding req_valid continuously is served within N jobs.
- Scheduler outputs carry no arithmetic; data passes through bit-exact. Saturation to ±1.0 (0x0080/0xFF80) is done by the rotator.
- req_valid dropped before accept: the request is simply not granted; no state change.
- req_valid and operands of a non-granted requester are ignored; operands are sampled only in the grant cycle.
- Reset asserted in any state: returns to IDLE next edge. No rsp_valid is produced for the in-flight job, and the ptr is reinitialised.
- Simultaneous all-N requests: service order 0,1,..,N-1,0,...
- Example with ptr=2 and requests {1,3}: 3 is granted, then 1.

Test Plan:
- Bench drives the scheduler against a behavioural rotator model: ready drops 1 cycle after start, returns after 10 cycles, output = input rotated by angle.
- Single job: req_valid[0], v0=0x0080, v1=0, angle=0 -> req_ready[0] pulses once, co_start one cycle later, then rsp_valid with rsp_id=0, rsp_v0=0x0080, rsp_v1=0, rsp_err=0.
- All 4 requesters valid continuously with distinct angles (0x0000, 0x0A2, 0x144, 0x1E6) -> rsp_id sequence 0,1,2,3,0. Each result matches its own operands; exactly one req_ready pulse per job.
- ptr=2 (after serving 2), only req 1 and 3 valid -> 3 granted before 1.
- Model never raises co_ready after start -> after TIMEOUT=31 cycles, rsp_valid with rsp_err=1 and rsp_v0=rsp_v1=0, then busy=0 and the next request is accepted.
- reset pulsed during WAIT_HI -> no rsp_valid, busy=0 and all outputs at reset values next cycle; a subsequent job from requester 0 completes normally.
- co_ready held low while in IDLE with req_valid set -> no req_ready and no co_start until co_ready returns to 1.
